// File: rtl/mul_arbiter_pkg.sv
// Shared types and helpers for the two-port multiplier arbiter.
// Contents:
//   OpW / ProdW - operand and product widths
//   grant_t     - one-hot grant vector {g1, g0}
//   arb_pick    - grant selection for fair (round-robin) or fixed-priority modes
package mul_arbiter_pkg;

    localparam int unsigned OpW   = 8;
    localparam int unsigned ProdW = 16;

    typedef struct packed {
        logic g1;
        logic g0;
    } grant_t;

    // last = index of the port granted on the most recent transfer.
    // Port 1 only wins contention when fair mode is on and port 0 went last.
    function automatic grant_t arb_pick(input logic v0, input logic v1,
                                        input logic last, input logic fair);
        grant_t g;
        logic   prefer1;
        prefer1 = fair & ~last;
        g.g0    = v0 & ~(v1 & prefer1);
        g.g1    = v1 & ~(v0 & ~prefer1);
        return g;
    endfunction

endpackage

// File: rtl/mul_ctrl_defs.vh
// Controller state encodings for mul_arbiter, included inside the module body.
localparam logic [1:0] StIdle = 2'd0;
localparam logic [1:0] StCalc = 2'd1;
localparam logic [1:0] StDone = 2'd2;

// File: rtl/mul_signed.sv
// Combinational signed 8x8 -> 16 multiplier.
// Ports:
//   a, b - two's complement operands
//   z    - exact signed product
module mul_signed (
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic signed [15:0] z
);

    // Sign-extend both operands first so the 16-bit product is exact.
    assign z = 16'(a) * 16'(b);

endmodule

// File: rtl/mul_arbiter.sv
// Two-port arbiter in front of a single shared signed multiplier.
// One request is accepted in IDLE, its product is registered in CALC, and the
// result is presented in DONE until the consumer takes it.
// Ports:
//   clk, clrn          - clock, asynchronous active-low reset
//   v0/a0/b0, r0       - port 0 request valid, operands, accepted
//   v1/a1/b1, r1       - port 1 request valid, operands, accepted
//   z_valid, z, z_id   - result valid, signed product, originating port
//   z_ready            - result consumer ready
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int unsigned FAIR = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             v0,
    input  logic [OpW-1:0]   a0,
    input  logic [OpW-1:0]   b0,
    output logic             r0,
    input  logic             v1,
    input  logic [OpW-1:0]   a1,
    input  logic [OpW-1:0]   b1,
    output logic             r1,
    output logic             z_valid,
    output logic [ProdW-1:0] z,
    output logic             z_id,
    input  logic             z_ready
);

    `include "mul_ctrl_defs.vh"

    localparam logic FairEn = (FAIR != 0);

    logic [1:0]       state_q, state_d;
    logic [OpW-1:0]   a_q, a_d;
    logic [OpW-1:0]   b_q, b_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic [ProdW-1:0] z_q, z_d;
    logic             z_id_q, z_id_d;
    logic [ProdW-1:0] prod;
    grant_t           gnt;

    mul_signed u_mul (
        .a (a_q),
        .b (b_q),
        .z (prod)
    );

    // Grants exist only in IDLE; a grant always implies the matching valid.
    always_comb begin
        gnt = arb_pick(v0, v1, last_q, FairEn);
        if (state_q != StIdle) begin
            gnt = '0;
        end
    end

    assign r0      = gnt.g0;
    assign r1      = gnt.g1;
    assign z_valid = (state_q == StDone);
    assign z       = z_q;
    assign z_id    = z_id_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        last_d  = last_q;
        z_d     = z_q;
        z_id_d  = z_id_q;
        case (state_q)
            StIdle: begin
                if (gnt.g0 | gnt.g1) begin
                    a_d     = gnt.g1 ? a1 : a0;
                    b_d     = gnt.g1 ? b1 : b0;
                    id_d    = gnt.g1;
                    last_d  = gnt.g1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // z/z_id change only here so they hold outside DONE.
                z_d     = prod;
                z_id_d  = id_q;
                state_d = StDone;
            end
            StDone: begin
                if (z_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;  // port 0 wins the first contention
            z_q     <= '0;
            z_id_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            last_q  <= last_d;
            z_q     <= z_d;
            z_id_q  <= z_id_d;
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: table of single requests, then
// backpressure, reset mid-CALC and contention sequences. A monitor pushes the
// expected result on every observed transfer and pops it when the result retires.
module tb_mul_arbiter;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        z_ready = 1'b1;
    logic        r0, r1, z_valid, z_id;
    logic [15:0] z;
    logic        fp_r0, fp_r1, fp_z_valid, fp_z_id;
    logic [15:0] fp_z;

    always #5 clk = ~clk;

    mul_arbiter #(.FAIR(1)) dut (
        .clk(clk), .clrn(clrn),
        .v0(v0), .a0(a0), .b0(b0), .r0(r0),
        .v1(v1), .a1(a1), .b1(b1), .r1(r1),
        .z_valid(z_valid), .z(z), .z_id(z_id), .z_ready(z_ready)
    );

    mul_arbiter #(.FAIR(0)) dut_fp (
        .clk(clk), .clrn(clrn),
        .v0(v0), .a0(a0), .b0(b0), .r0(fp_r0),
        .v1(v1), .a1(a1), .b1(b1), .r1(fp_r1),
        .z_valid(fp_z_valid), .z(fp_z), .z_id(fp_z_id), .z_ready(z_ready)
    );

    typedef struct {
        logic [15:0] z;
        logic        id;
        int          t;
    } exp_t;

    typedef struct {
        logic        port;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] z;
    } vec_t;

    exp_t        sb[$];
    int          glog[$];
    int          fplog[$];
    logic [15:0] exp0 = '0, exp1 = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        zv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!clrn) begin
            zv_prev = 1'b0;
        end else begin
            if (r0 && v0) begin
                sb.push_back('{exp0, 1'b0, cyc});
                glog.push_back(0);
            end
            if (r1 && v1) begin
                sb.push_back('{exp1, 1'b1, cyc});
                glog.push_back(1);
            end
            if (fp_r0 && v0) fplog.push_back(0);
            if (fp_r1 && v1) fplog.push_back(1);
            if (z_valid && !zv_prev) begin
                if (sb.size() == 0) check("latency_no_request", 0, 1);
                else check("latency", cyc - sb[0].t, 2);
            end
            if (z_valid && z_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 0, 1);
                end else begin
                    e = sb.pop_front();
                    check("z", int'(z), int'(e.z));
                    check("z_id", int'(z_id), int'(e.id));
                end
            end
            zv_prev = z_valid;
        end
    end

    task automatic issue(input logic port, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] e);
        int k;
        @(posedge clk); #1;
        if (port) begin a1 = a; b1 = b; exp1 = e; v1 = 1'b1; end
        else      begin a0 = a; b0 = b; exp0 = e; v0 = 1'b1; end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(port ? r1 : r0) && k < 20);
        if (k >= 20) check("timeout_grant", 0, 1);
        @(posedge clk); #1;
        if (port) v1 = 1'b0;
        else v0 = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while ((sb.size() != 0 || z_valid) && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (k >= lim) check("timeout_idle", 0, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        clrn = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        clrn = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin
        int k;
        vecs[0] = '{1'b0, 8'hFD, 8'h05, 16'hFFF1};
        vecs[1] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[2] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        vecs[3] = '{1'b0, 8'h00, 8'h9C, 16'h0000};
        vecs[4] = '{1'b1, 8'h0C, 8'h0A, 16'h0078};
        vecs[5] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[6] = '{1'b0, 8'h7F, 8'h7F, 16'h3F01};
        vecs[7] = '{1'b1, 8'hFF, 8'h7F, 16'hFF81};

        // Reset state.
        @(negedge clk);
        check("rst_z_valid", int'(z_valid), 0);
        check("rst_z", int'(z), 0);
        check("rst_z_id", int'(z_id), 0);
        check("rst_r0", int'(r0), 0);
        check("rst_r1", int'(r1), 0);
        @(posedge clk); #1;
        clrn = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].z);
            wait_idle(20);
        end

        // Backpressure with a second request waiting on port 1.
        z_ready = 1'b0;
        issue(1'b0, 8'h12, 8'h03, 16'h0036);
        a1 = 8'h02; b1 = 8'hFE; exp1 = 16'hFFFC; v1 = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!z_valid && k < 10);
        if (k >= 10) check("timeout_done", 0, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_z_valid", int'(z_valid), 1);
            check("bp_z", int'(z), 16'h0036);
            check("bp_z_id", int'(z_id), 0);
            check("bp_r0", int'(r0), 0);
            check("bp_r1", int'(r1), 0);
        end
        @(posedge clk); #1;
        z_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_after_z_valid", int'(z_valid), 0);
        check("bp_after_r1", int'(r1), 1);
        @(posedge clk); #1;
        v1 = 1'b0;
        wait_idle(20);

        // Reset while in CALC discards the product.
        issue(1'b0, 8'h05, 8'h06, 16'h001E);
        clrn = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_z", int'(z), 0);
        check("mid_rst_z_id", int'(z_id), 0);
        @(posedge clk); #1;
        clrn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_valid", int'(z_valid), 0);
        end
        issue(1'b1, 8'hF9, 8'h03, 16'hFFEB);
        wait_idle(20);

        // Contention from reset: fair gives 0,1,0; fixed priority gives 0,0,0.
        pulse_reset();
        glog.delete();
        fplog.delete();
        a0 = 8'h03; b0 = 8'h04; exp0 = 16'h000C;
        a1 = 8'hF0; b1 = 8'h02; exp1 = 16'hFFE0;
        v0 = 1'b1; v1 = 1'b1;
        k = 0;
        while (glog.size() < 3 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 30) check("timeout_contention", 0, 1);
        v0 = 1'b0; v1 = 1'b0;
        wait_idle(20);
        check("fair_grants", glog.size(), 3);
        check("fixed_grants", fplog.size(), 3);
        if (glog.size() >= 3) begin
            check("fair_grant0", glog[0], 0);
            check("fair_grant1", glog[1], 1);
            check("fair_grant2", glog[2], 0);
        end
        if (fplog.size() >= 3) begin
            for (int i = 0; i < 3; i++) check("fixed_grant", fplog[i], 0);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter FAIR, default 1, meaning 1 = round-robin grant between ports and 0 = fixed priority to port 0.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clrn, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port v0, input, 1, port-0 request valid.
REQ-005 SHALL have port a0, input, 8, port-0 multiplicand (two's complement).
REQ-006 SHALL have port b0, input, 8, port-0 multiplier (two's complement).
REQ-007 SHALL have port r0, output, 1, port-0 request accepted (ready).
REQ-008 SHALL have ports v1, a1, b1 and r1 with the same directions, widths and meanings for port 1.
REQ-009 SHALL have port z_valid, output, 1, result valid.
REQ-010 SHALL have port z, output, 16, signed product a*b.
REQ-011 SHALL have port z_id, output, 1, index of the port that issued the request.
REQ-012 SHALL have port z_ready, input, 1, result consumer ready.

Function
REQ-013 SHALL implement an FSM with three states: IDLE, CALC and DONE.
REQ-014 In IDLE, SHALL assert at most one of r0/r1, combinationally, only for a port whose v is high; the selected port is the grant.
REQ-015 r0 and r1 SHALL be 0 in CALC and DONE.
REQ-016 On a transfer (vX & rX at an edge), SHALL latch aX/bX into operand registers, latch X into the id register, and move IDLE->CALC.
REQ-017 In CALC, SHALL feed the operand registers to the multiplier, register the 16-bit product into z at the edge, and move CALC->DONE.
REQ-018 In DONE, SHALL hold z_valid=1 with z and z_id stable until z_ready=1 at an edge, then move DONE->IDLE.
REQ-019 Latency SHALL be: transfer edge at cycle T, z_valid high from cycle T+2; maximum throughput one product per 3 cycles.
REQ-020 z_valid SHALL be 0 in IDLE and CALC; z and z_id SHALL hold their last value outside DONE.
REQ-021 With FAIR=1 and both v high, SHALL grant the port not granted last; with one v high, SHALL grant that port regardless of history.
REQ-022 With FAIR=0 and both v high, SHALL always grant port 0.
REQ-023 The last-grant register SHALL update only on a transfer.
REQ-024 A request arriving while the block is busy SHALL wait with r=0; the requester keeps v and its operands stable until accepted.
REQ-025 The product SHALL be exact signed 8x8->16 with no saturation; -128*-128 = 16'h4000.
REQ-026 z_ready held high in DONE SHALL retire the result after exactly one DONE cycle.
REQ-027 An illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-028 While clrn=0, SHALL force: state IDLE, z_valid 0, z 16'h0000, z_id 0, operand registers 0, last-grant 1 (so port 0 wins the first contention).
REQ-029 Reset asserted mid-operation (CALC or DONE) SHALL discard the pending product; no z_valid pulse after release.

Structure
REQ-030 State encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) SHALL live in shared include file mul_ctrl_defs.vh.
REQ-031 SHALL instantiate the team's existing combinational 8x8 signed multiplier sub-module, mul_signed (a, b -> z), once; no other arithmetic in this block.

Verification
REQ-032 Single request: v0=1, a0=8'hFD, b0=8'h05 -> r0=1 at T, z_valid at T+2, z=16'hFFF1, z_id=0.
REQ-033 Corner products: 8'h80*8'h80 -> 16'h4000; 8'h7F*8'h80 -> 16'hC080; 8'h00*8'h9C -> 16'h0000.
REQ-034 Contention with FAIR=1: v0=v1=1 held for three results -> grant order 0,1,0; with FAIR=0 -> 0,0,0.
REQ-035 Backpressure: z_ready=0 for 5 cycles in DONE -> z/z_id/z_valid stable, r0=r1=0 throughout; z_ready=1 -> IDLE next cycle.
REQ-036 Reset mid-CALC: pull clrn low for 1 cycle -> z_valid stays 0, state IDLE; the next request is served with normal latency.
